// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, addressing modes and the fetch FSM state type.
package cpu_pkg;

    localparam logic [5:0] JMP   = 6'b001_001;
    localparam logic [5:0] BEQL  = 6'b010_000;
    localparam logic [5:0] BNEQL = 6'b010_001;
    localparam logic [5:0] LOAD  = 6'b100_000;
    localparam logic [5:0] POP   = 6'b100_100;
    localparam logic [5:0] PUSH  = 6'b100_110;
    localparam logic [5:0] ADD   = 6'b110_000;

    localparam logic [2:0] REGDIR = 3'b000;
    localparam logic [2:0] MEMDIR = 3'b001;
    localparam logic [2:0] PCREL  = 3'b010;
    localparam logic [2:0] IMMED  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_len_dec.sv
// Instruction length decoder: says whether the bytes read so far complete the instruction.
module fetch_len_dec
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [2:0] funct,
    input  logic       after_b1,
    output logic       done
);

    always_comb begin
        done = 1'b0;
        if (!after_b1) begin
            done = (op == POP) || (op == PUSH);
        end else if (op == JMP || op == BEQL || op == BNEQL) begin
            done = 1'b1;
        end else if (op == LOAD) begin
            done = 1'b0;
        end else begin
            done = (funct == REGDIR);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads 1..3 bytes over req/ack and
// presents the assembled IR fields plus pc + length.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [5:0]        op,
    output logic [2:0]        funct,
    output logic [7:0]        ir_b1,
    output logic [7:0]        ir_b2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] pc_next,
    output logic              busy,
    output logic              fetch_done
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc, pc_d, addr_d, pcn_d;
    logic              req_d, busy_d, done_d;
    logic [5:0]        op_d, dec_op;
    logic [2:0]        funct_d;
    logic [7:0]        b1_d, b2_d;
    logic [1:0]        len_d, nbytes;
    logic              ack, len_done;

    // An ack only counts while a request is actually outstanding
    assign ack    = mem_req && mem_ack;
    assign dec_op = (state == RD0) ? mem_rdata[7:2] : op;

    fetch_len_dec u_len_dec (
        .op       (dec_op),
        .funct    (mem_rdata[7:5]),
        .after_b1 (state == RD1),
        .done     (len_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            op         <= '0;
            funct      <= '0;
            ir_b1      <= '0;
            ir_b2      <= '0;
            instr_len  <= '0;
            pc_next    <= '0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_d;
            mem_req    <= req_d;
            mem_addr   <= addr_d;
            op         <= op_d;
            funct      <= funct_d;
            ir_b1      <= b1_d;
            ir_b2      <= b2_d;
            instr_len  <= len_d;
            pc_next    <= pcn_d;
            busy       <= busy_d;
            fetch_done <= done_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fetch_start) state_nx = RD0;
            RD0:     if (ack) state_nx = len_done ? DONE : RD1;
            RD1:     if (ack) state_nx = len_done ? DONE : RD2;
            RD2:     if (ack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            RD1:     nbytes = 2'd2;
            RD2:     nbytes = 2'd3;
            default: nbytes = 2'd1;
        endcase
    end

    always_comb begin
        pc_d    = pc;
        req_d   = mem_req;
        addr_d  = mem_addr;
        op_d    = op;
        funct_d = funct;
        b1_d    = ir_b1;
        b2_d    = ir_b2;
        len_d   = instr_len;
        pcn_d   = pc_next;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    pc_d    = pc_in;
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    op_d    = '0;
                    funct_d = '0;
                    b1_d    = '0;
                    b2_d    = '0;
                end
            end
            RD0, RD1, RD2: begin
                // A low request inside a read state is the one-cycle gap
                if (!mem_req) begin
                    req_d = 1'b1;
                end else if (mem_ack) begin
                    req_d = 1'b0;
                    case (state)
                        RD0: op_d = mem_rdata[7:2];
                        RD1: begin
                            b1_d    = mem_rdata;
                            funct_d = mem_rdata[7:5];
                        end
                        default: b2_d = mem_rdata;
                    endcase
                    if (state_nx == DONE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        len_d  = nbytes;
                        pcn_d  = pc + {{(ADDR_W-2){1'b0}}, nbytes};
                    end else begin
                        addr_d = mem_addr + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory responder
// and an instruction-level reference model.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_start;
    logic [7:0] pc_in;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [5:0] op;
    logic [2:0] funct;
    logic [7:0] ir_b1;
    logic [7:0] ir_b2;
    logic [1:0] instr_len;
    logic [7:0] pc_next;
    logic       busy;
    logic       fetch_done;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .op          (op),
        .funct       (funct),
        .ir_b1       (ir_b1),
        .ir_b2       (ir_b2),
        .instr_len   (instr_len),
        .pc_next     (pc_next),
        .busy        (busy),
        .fetch_done  (fetch_done)
    );

    logic [7:0] mem [256];
    logic [7:0] rd_addr [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         delay = 0;
    bit         spur = 1'b0;
    bit         armed = 1'b0;
    int         start_cyc = 0;
    int         done_seen = 0;

    logic [7:0] e_pc, e_b1, e_b2, e_pcn;
    logic [5:0] e_op;
    logic [2:0] e_funct;
    int         e_len;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Instruction length from the opcode/addressing-mode rules
    function automatic int model_len(input logic [7:0] b0, input logic [7:0] b1);
        logic [5:0] o;
        o = b0[7:2];
        if (o == 6'b100100 || o == 6'b100110) return 1;
        if (o == 6'b001001 || o == 6'b010000 || o == 6'b010001) return 2;
        if (o == 6'b100000) return 3;
        return (b1[7:5] == 3'b000) ? 2 : 3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ack after 'delay' wait cycles, optional stray ack
    initial begin
        int w;
        w = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (mem_req === 1'b1) begin
                if (w >= delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    rd_addr.push_back(mem_addr);
                    w = 0;
                end else begin
                    mem_ack = 1'b0;
                    w++;
                end
            end else begin
                w = 0;
                mem_ack = spur;
                mem_rdata = spur ? 8'hEE : 8'h00;
                spur = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed && mem_req === 1'b1) chk("busy_with_req", busy, 1);
        if (fetch_done === 1'b1) begin
            if (!armed) begin
                chk("unexpected_done", fetch_done, 0);
            end else begin
                chk("op", op, e_op);
                chk("funct", funct, e_funct);
                chk("ir_b1", ir_b1, e_b1);
                chk("ir_b2", ir_b2, e_b2);
                chk("instr_len", instr_len, e_len);
                chk("pc_next", pc_next, e_pcn);
                chk("busy_at_done", busy, 0);
                chk("mem_req_at_done", mem_req, 0);
                chk("latency", cyc - start_cyc, e_len * (2 + delay));
                chk("n_reads", rd_addr.size(), e_len);
                for (int i = 0; i < rd_addr.size() && i < 3; i++) begin
                    logic [7:0] a;
                    a = e_pc + 8'(i);
                    chk("rd_addr", rd_addr[i], a);
                end
                armed = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic do_fetch(input logic [7:0] pc, input int d, input bit disturb);
        logic [7:0] a1, a2;
        int n;
        @(negedge clk);
        a1 = pc + 8'd1;
        a2 = pc + 8'd2;
        e_pc = pc;
        e_len = model_len(mem[pc], mem[a1]);
        e_op = mem[pc][7:2];
        e_b1 = (e_len >= 2) ? mem[a1] : 8'h00;
        e_funct = e_b1[7:5];
        e_b2 = (e_len == 3) ? mem[a2] : 8'h00;
        e_pcn = pc + 8'(e_len);
        delay = d;
        rd_addr.delete();
        start_cyc = cyc;
        armed = 1'b1;
        n = done_seen;
        fetch_start = 1'b1;
        pc_in = pc;
        @(negedge clk);
        fetch_start = 1'b0;
        pc_in = 8'hA5;
        if (disturb) begin
            @(negedge clk);
            fetch_start = 1'b1;
            pc_in = 8'h33;
            spur = 1'b1;
            @(negedge clk);
            fetch_start = 1'b0;
        end
        for (int i = 0; i < 100 && done_seen == n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_timeout", done_seen, n + 1);
        armed = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_op"}, op, 0);
        chk({tag, "_funct"}, funct, 0);
        chk({tag, "_ir_b1"}, ir_b1, 0);
        chk({tag, "_ir_b2"}, ir_b2, 0);
        chk({tag, "_instr_len"}, instr_len, 0);
        chk({tag, "_pc_next"}, pc_next, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fetch_done"}, fetch_done, 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'd10] = 8'h98;
        mem[8'd20] = 8'h24; mem[8'd21] = 8'h40; mem[8'd22] = 8'h55;
        mem[8'd30] = 8'hC0; mem[8'd31] = 8'h03; mem[8'd32] = 8'hAA;
        mem[8'd40] = 8'hC0; mem[8'd41] = 8'hE3; mem[8'd42] = 8'h7F;
        mem[8'hFF] = 8'h80; mem[8'h00] = 8'h00; mem[8'h01] = 8'h5A;
        mem[8'd50] = 8'h04; mem[8'd51] = 8'h23; mem[8'd52] = 8'h99;
        mem[8'd60] = 8'h80; mem[8'd61] = 8'h20; mem[8'd62] = 8'h11;

        reset = 1'b1;
        fetch_start = 1'b0;
        pc_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        do_fetch(8'd10, 0, 1'b0);
        chk("t1_op", op, 6'b100110);
        chk("t1_len", instr_len, 1);
        chk("t1_pc_next", pc_next, 8'd11);

        do_fetch(8'd20, 2, 1'b0);
        chk("t2_op", op, 6'b001001);
        chk("t2_ir_b1", ir_b1, 8'h40);
        chk("t2_funct", funct, 3'b010);
        chk("t2_ir_b2", ir_b2, 8'h00);
        chk("t2_pc_next", pc_next, 8'd22);

        do_fetch(8'd30, 0, 1'b0);
        chk("t3a_len", instr_len, 2);

        do_fetch(8'd40, 1, 1'b0);
        chk("t3b_len", instr_len, 3);
        chk("t3b_funct", funct, 3'b111);
        chk("t3b_ir_b2", ir_b2, 8'h7F);

        do_fetch(8'hFF, 0, 1'b0);
        chk("t4_pc_next", pc_next, 8'h02);
        chk("t4_len", instr_len, 3);

        do_fetch(8'd50, 0, 1'b1);
        chk("t5_len", instr_len, 3);
        chk("t5_ir_b2", ir_b2, 8'h99);
        chk("t5_pc_next", pc_next, 8'd53);

        // Abort a LOAD while its third byte is being requested
        @(negedge clk);
        delay = 3;
        rd_addr.delete();
        fetch_start = 1'b1;
        pc_in = 8'd60;
        @(negedge clk);
        fetch_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            found = (mem_req === 1'b1) && (rd_addr.size() == 2);
        end
        chk("t6_reach_rd2", found, 1);
        chk("t6_rd2_addr", mem_addr, 8'd62);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("t6");
        reset = 1'b0;
        do_fetch(8'd60, 0, 1'b0);
        chk("t6_refetch_len", instr_len, 3);
        chk("t6_refetch_b1", ir_b1, 8'h20);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
